mod_reduce_stage: RTL and testbench

Third stage of the modular adder/subtractor pipeline, directly downstream of the second-stage select multiplexers. It accepts the selected partial vector (a3..a0) and the shifted carry vector (b4..b1), then forms their full sum. It reduces that sum modulo the fixed modulus by iterative compare-and-subtract, and presents a registered result under a valid/ready handshake. It is the first clocked stage of the datapath.

---
 rtl/mod_pkg.sv | 19 +
 rtl/mod_sub_step.sv | 20 ++
 rtl/mod_reduce_stage.sv | 109 ++++++++++
 tb/tb_mod_reduce_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mod_pkg.sv
// Shared constants, state type and raw-sum helper for the modular reduce stage.
package mod_pkg;

   localparam logic [3:0]  M_DEFAULT = 4'b1100;
   localparam int unsigned RAW_W     = 6;
   localparam int unsigned RES_W     = 4;

   typedef enum logic [1:0] {
      IDLE,
      RED,
      DONE
   } state_e;

   // Partial bits carry weight 2^0..2^3, carry bits 2^1..2^4; 6 bits holds the max of 45.
   function automatic logic [RAW_W-1:0] raw_sum(input logic [3:0] pa, input logic [3:0] pb);
      return {2'b00, pa} + {1'b0, pb, 1'b0};
   endfunction

endpackage

// File: rtl/mod_sub_step.sv
// One compare-and-subtract step of the modular reduction (combinational).
module mod_sub_step
   import mod_pkg::*;
(
   input  logic [RAW_W-1:0] acc,
   input  logic [3:0]       m,
   output logic [RAW_W-1:0] next_acc,
   output logic             ge
);

   logic [RAW_W-1:0] m_ext;

   // Modulus is zero-extended so the compare happens at full accumulator width.
   always_comb begin
      m_ext    = {2'b00, m};
      ge       = (acc >= m_ext);
      next_acc = acc - m_ext;
   end

endmodule

// File: rtl/mod_reduce_stage.sv
// Third pipeline stage: forms a + 2*b and reduces it modulo M by repeated
// subtraction, returning the result under a valid/ready handshake.
// Optional statistics outputs (done_cnt, last_iter) are enabled by defining
// MOD_REDUCE_STATS_EN.
module mod_reduce_stage
   import mod_pkg::*;
#(
   parameter logic [3:0] M = M_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             s,
   input  logic [3:0]       a,
   input  logic [3:0]       b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] result,
`ifdef MOD_REDUCE_STATS_EN
   output logic [7:0]       done_cnt,
   output logic [RAW_W-1:0] last_iter,
`endif
   output logic             s_out
);

   state_e           state_q;
   logic [RAW_W-1:0] acc_q;
   logic [RAW_W-1:0] acc_sub;
   logic             acc_ge;

`ifdef MOD_REDUCE_STATS_EN
   logic [RAW_W-1:0] iter_q;
`endif

   mod_sub_step u_sub_step (
      .acc      (acc_q),
      .m        (M),
      .next_acc (acc_sub),
      .ge       (acc_ge)
   );

   // Accept only while idle; no bypass from the output handshake.
   assign in_ready = (state_q == IDLE);

   // Control FSM with registered datapath and outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         result    <= '0;
         s_out     <= 1'b0;
         out_valid <= 1'b0;
`ifdef MOD_REDUCE_STATS_EN
         iter_q    <= '0;
         last_iter <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  acc_q   <= raw_sum(a, b);
                  s_out   <= s;
                  state_q <= RED;
`ifdef MOD_REDUCE_STATS_EN
                  iter_q  <= '0;
`endif
               end
            end
            RED: begin
               if (acc_ge) begin
                  acc_q  <= acc_sub;
`ifdef MOD_REDUCE_STATS_EN
                  iter_q <= iter_q + 1'b1;
`endif
               end else begin
                  result    <= acc_q[RES_W-1:0];
                  out_valid <= 1'b1;
                  state_q   <= DONE;
`ifdef MOD_REDUCE_STATS_EN
                  last_iter <= iter_q;
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

`ifdef MOD_REDUCE_STATS_EN
   // Completed-transaction counter, wraps naturally at 8 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_cnt <= '0;
      end else if (out_valid && out_ready) begin
         done_cnt <= done_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mod_reduce_stage.sv
// Directed self-checking bench for mod_reduce_stage (M = 12).
module tb_mod_reduce_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic       s;
   logic [3:0] a;
   logic [3:0] b;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] result;
   logic       s_out;
`ifdef MOD_REDUCE_STATS_EN
   logic [7:0] done_cnt;
   logic [5:0] last_iter;
`endif

   int checks = 0;
   int errors = 0;
   int exp_done = 0;

   mod_reduce_stage #(
      .M (4'd12)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .s         (s),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
`ifdef MOD_REDUCE_STATS_EN
      .done_cnt  (done_cnt),
      .last_iter (last_iter),
`endif
      .s_out     (s_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One transaction with out_ready held high; checks latency, data and release.
   task automatic run_txn(input logic [3:0] ta, input logic [3:0] tb_v, input logic ts,
                          input int exp_edges, input int exp_res, input string tag);
      int n;
      a         = ta;
      b         = tb_v;
      s         = ts;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      check({tag, "_busy"}, in_ready, 0);
      n = 0;
      while (!out_valid && n < 64) begin
         step();
         n++;
      end
      check({tag, "_edges"}, n, exp_edges);
      check({tag, "_result"}, result, exp_res);
      check({tag, "_s_out"}, s_out, ts);
      step();
      exp_done++;
      check({tag, "_released"}, out_valid, 0);
      check({tag, "_in_ready"}, in_ready, 1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      s         = 1'b0;
      a         = 4'd0;
      b         = 4'd0;
      out_ready = 1'b0;
      #2;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      check("rst_s_out", s_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // raw=5 -> k=0
      run_txn(4'd5, 4'd0, 1'b0, 1, 5, "r5");
      // raw=45 -> k=3, 45-36=9
      run_txn(4'd15, 4'd15, 1'b1, 4, 9, "r45");
`ifdef MOD_REDUCE_STATS_EN
      check("r45_last_iter", last_iter, 3);
      check("r45_done_cnt", done_cnt, exp_done);
`endif
      // raw=M -> k=1, result 0
      run_txn(4'd4, 4'd4, 1'b0, 2, 0, "r12");
      // raw=M-1 -> k=0
      run_txn(4'd11, 4'd0, 1'b1, 1, 11, "r11");
      // raw=0
      run_txn(4'd0, 4'd0, 1'b0, 1, 0, "r0");
      // raw=3+2*7=17 -> k=1, result 5
      run_txn(4'd3, 4'd7, 1'b1, 2, 5, "r17");

      // Backpressure: raw=7+2=9, held for 5 cycles while upstream pushes new data.
      a         = 4'd7;
      b         = 4'd1;
      s         = 1'b1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("bp_valid", out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         a        = 4'(i + 1);
         b        = 4'd3;
         s        = 1'b0;
         step();
         check("bp_hold_result", result, 9);
         check("bp_hold_s_out", s_out, 1);
         check("bp_hold_in_ready", in_ready, 0);
         check("bp_hold_valid", out_valid, 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      exp_done++;
      check("bp_release_valid", out_valid, 0);
      check("bp_release_in_ready", in_ready, 1);
      step();
      step();
      check("bp_nocapture_in_ready", in_ready, 1);
      check("bp_nocapture_valid", out_valid, 0);

      // Reset while in RED drops the transaction.
      a         = 4'd15;
      b         = 4'd15;
      s         = 1'b1;
      in_valid  = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("mid_busy", in_ready, 0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_result", result, 0);
      check("mid_rst_s_out", s_out, 0);
`ifdef MOD_REDUCE_STATS_EN
      check("mid_rst_done_cnt", done_cnt, 0);
      check("mid_rst_last_iter", last_iter, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         check("post_rst_valid", out_valid, 0);
      end

`ifdef MOD_REDUCE_STATS_EN
      // 257 completions wrap the counter to 1.
      for (int i = 0; i < 257; i++) begin
         run_txn(4'd2, 4'd1, 1'b0, 1, 4, "wrap");
      end
      check("wrap_done_cnt", done_cnt, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule
